s_rca_seq_ctrl: RTL

Multi-cycle sequencer that computes exact signed WIDTH-bit add/subtract results by time-multiplexing one internal CHUNK-bit ripple-carry adder slice.
- Low-to-high, one chunk per cycle, with a registered carry between chunks.
- Produces a WIDTH+1-bit signed result using the same sign-extension rule as our flat signed RCA generators.
- Sits between a valid/ready operand source and a valid/ready result sink where area beats latency.

---
 rtl/s_rca_seq_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/s_rca_seq_ctrl.sv
// rtl/s_rca_seq_ctrl.sv - signed add/subtract sequenced one CHUNK-bit ripple slice per cycle
module s_rca_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             out_ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic              carry;
    logic [IDXW-1:0]   idx;
    logic [CHUNK-1:0]  a_chunk;
    logic [CHUNK-1:0]  b_chunk;
    logic [CHUNK:0]    slice;
    logic              last;
    logic              top_bit;

    // b_r already holds ~B for subtraction, so the sign-extension bit follows from it directly
    always_comb begin
        a_chunk = a_r[idx*CHUNK +: CHUNK];
        b_chunk = b_r[idx*CHUNK +: CHUNK];
        slice   = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
        last    = (idx == IDXW'(NCHUNK - 1));
        top_bit = a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ slice[CHUNK];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            carry   <= 1'b0;
            idx     <= '0;
            out_sum <= '0;
            out_ovf <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= in_a;
                        b_r   <= in_sub ? ~in_b : in_b;
                        carry <= in_sub;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    out_sum[idx*CHUNK +: CHUNK] <= slice[CHUNK-1:0];
                    carry <= slice[CHUNK];
                    idx   <= idx + 1'b1;
                    if (last) begin
                        out_sum[WIDTH] <= top_bit;
                        out_ovf        <= top_bit ^ slice[CHUNK-1];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
